// File: rtl/vx_mem_nc_responder.sv
// Memory-side responder for the non-cacheable bypass path.
// Line-wide scratch store, fixed-latency read pipe, FWFT response queue.
module vx_mem_nc_responder #(
  parameter int MEM_ADDR_WIDTH = 6,
  parameter int MEM_DATA_SIZE  = 16,
  parameter int MEM_TAG_WIDTH  = 8,
  parameter int LATENCY        = 2,
  parameter int RSP_QUEUE_SIZE = 4,
  parameter bit WRITE_RSP      = 1'b0,
  parameter int MEM_DATA_WIDTH = MEM_DATA_SIZE * 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_req_valid,
  input  logic                      mem_req_rw,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_req_addr,
  input  logic [MEM_DATA_SIZE-1:0]  mem_req_byteen,
  input  logic [MEM_DATA_WIDTH-1:0] mem_req_data,
  input  logic [MEM_TAG_WIDTH-1:0]  mem_req_tag,
  output logic                      mem_req_ready,
  output logic                      mem_rsp_valid,
  output logic [MEM_DATA_WIDTH-1:0] mem_rsp_data,
  output logic [MEM_TAG_WIDTH-1:0]  mem_rsp_tag,
  input  logic                      mem_rsp_ready,
  output logic                      busy
);

  localparam int DEPTH = 2 ** MEM_ADDR_WIDTH;
  localparam int QAW   = $clog2(RSP_QUEUE_SIZE);
  localparam int CW    = $clog2(RSP_QUEUE_SIZE + 1);
  localparam logic [CW-1:0] CMAX = CW'(RSP_QUEUE_SIZE);
  localparam logic [CW-1:0] CONE = CW'(1);
  localparam logic [QAW:0]  PONE = (QAW + 1)'(1);

  logic [MEM_DATA_WIDTH-1:0] store [DEPTH];

  logic                      up;
  logic [CW-1:0]             cnt;
  logic [LATENCY-1:0]        pv;
  logic [MEM_DATA_WIDTH-1:0] pd [LATENCY];
  logic [MEM_TAG_WIDTH-1:0]  pt [LATENCY];

  logic [MEM_DATA_WIDTH-1:0] fd [RSP_QUEUE_SIZE];
  logic [MEM_TAG_WIDTH-1:0]  ft [RSP_QUEUE_SIZE];
  logic [QAW:0]              wr_ptr;
  logic [QAW:0]              rd_ptr;

  logic silent;
  logic req_fire;
  logic wr_fire;
  logic rsp_gen;
  logic rsp_fire;
  logic push;
  logic empty;
  logic full;

  // Silent writes never enter the response path, so they need no credit.
  assign silent   = mem_req_rw && !WRITE_RSP;
  assign mem_req_ready = up && (silent || (cnt < CMAX));
  assign req_fire = mem_req_valid && mem_req_ready;
  assign wr_fire  = req_fire && mem_req_rw;
  assign rsp_gen  = req_fire && !silent;

  assign push  = pv[LATENCY-1];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[QAW] != rd_ptr[QAW]) &&
                 (wr_ptr[QAW-1:0] == rd_ptr[QAW-1:0]);

  assign mem_rsp_valid = !empty;
  assign mem_rsp_data  = fd[rd_ptr[QAW-1:0]];
  assign mem_rsp_tag   = ft[rd_ptr[QAW-1:0]];
  assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;

  assign busy = (cnt != '0) || (|pv);

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < MEM_DATA_SIZE; b++) begin
        if (mem_req_byteen[b]) begin
          store[mem_req_addr][b*8 +: 8] <= mem_req_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    pd[0] <= mem_req_rw ? '0 : store[mem_req_addr];
    pt[0] <= mem_req_tag;
    for (int i = 1; i < LATENCY; i++) begin
      pd[i] <= pd[i-1];
      pt[i] <= pt[i-1];
    end
    if (push) begin
      fd[wr_ptr[QAW-1:0]] <= pd[LATENCY-1];
      ft[wr_ptr[QAW-1:0]] <= pt[LATENCY-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up     <= 1'b0;
      pv     <= '0;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      up <= 1'b1;
      pv <= LATENCY'({pv, rsp_gen});
      if (push) begin
        wr_ptr <= wr_ptr + PONE;
      end
      if (rsp_fire) begin
        rd_ptr <= rd_ptr + PONE;
      end
      unique case (1'b1)
        rsp_gen && !rsp_fire: cnt <= cnt + CONE;
        !rsp_gen && rsp_fire: cnt <= cnt - CONE;
        default: ;
      endcase
    end
  end

  a_latency_range: assert property (
    @(posedge clk) (LATENCY >= 1) && (LATENCY <= 8));

  a_fifo_overflow: assert property (
    @(posedge clk) disable iff (!reset) !(push && full));

  a_req_hold: assert property (
    @(posedge clk) disable iff (!reset)
    mem_req_valid && !mem_req_ready |=>
      mem_req_valid &&
      $stable(mem_req_rw) &&
      $stable(mem_req_addr) &&
      $stable(mem_req_byteen) &&
      $stable(mem_req_data) &&
      $stable(mem_req_tag));

endmodule

// File: tb/tb_vx_mem_nc_responder.sv
// Directed bench for vx_mem_nc_responder: a silent-write instance
// and a WRITE_RSP=1 instance sharing clock and reset.
module tb_vx_mem_nc_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         req_valid, req_rw, req_ready;
  logic [5:0]   req_addr;
  logic [15:0]  req_byteen;
  logic [127:0] req_data;
  logic [7:0]   req_tag;
  logic         rsp_valid, rsp_ready, busy;
  logic [127:0] rsp_data;
  logic [7:0]   rsp_tag;

  logic         req_valid_w, req_rw_w, req_ready_w;
  logic [5:0]   req_addr_w;
  logic [15:0]  req_byteen_w;
  logic [127:0] req_data_w;
  logic [7:0]   req_tag_w;
  logic         rsp_valid_w, rsp_ready_w, busy_w;
  logic [127:0] rsp_data_w;
  logic [7:0]   rsp_tag_w;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   got_tag[$];
  logic [127:0] got_data[$];
  logic [7:0]   got_tag_w[$];
  logic [127:0] got_data_w[$];

  localparam logic [127:0] LINE5 = {64'h0, {8{8'hAA}}};

  vx_mem_nc_responder #(.WRITE_RSP(1'b0)) u_dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(req_valid), .mem_req_rw(req_rw),
    .mem_req_addr(req_addr), .mem_req_byteen(req_byteen),
    .mem_req_data(req_data), .mem_req_tag(req_tag),
    .mem_req_ready(req_ready),
    .mem_rsp_valid(rsp_valid), .mem_rsp_data(rsp_data),
    .mem_rsp_tag(rsp_tag), .mem_rsp_ready(rsp_ready),
    .busy(busy)
  );

  vx_mem_nc_responder #(.WRITE_RSP(1'b1)) u_dut_w (
    .clk(clk), .reset(reset),
    .mem_req_valid(req_valid_w), .mem_req_rw(req_rw_w),
    .mem_req_addr(req_addr_w), .mem_req_byteen(req_byteen_w),
    .mem_req_data(req_data_w), .mem_req_tag(req_tag_w),
    .mem_req_ready(req_ready_w),
    .mem_rsp_valid(rsp_valid_w), .mem_rsp_data(rsp_data_w),
    .mem_rsp_tag(rsp_tag_w), .mem_rsp_ready(rsp_ready_w),
    .busy(busy_w)
  );

  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      got_tag.push_back(rsp_tag);
      got_data.push_back(rsp_data);
    end
    if (reset && rsp_valid_w && rsp_ready_w) begin
      got_tag_w.push_back(rsp_tag_w);
      got_data_w.push_back(rsp_data_w);
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic rw, input logic [5:0] a,
                      input logic [15:0] be, input logic [127:0] d,
                      input logic [7:0] t);
    bit ok = 1'b0;
    req_rw = rw; req_addr = a; req_byteen = be;
    req_data = d; req_tag = t; req_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      ok = req_ready;
      tick();
    end
    req_valid = 1'b0;
    chk($sformatf("accept_%0h", t), {127'd0, ok}, 128'd1);
  endtask

  task automatic send_w(input logic rw, input logic [5:0] a,
                        input logic [15:0] be, input logic [127:0] d,
                        input logic [7:0] t);
    bit ok = 1'b0;
    req_rw_w = rw; req_addr_w = a; req_byteen_w = be;
    req_data_w = d; req_tag_w = t; req_valid_w = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      ok = req_ready_w;
      tick();
    end
    req_valid_w = 1'b0;
    chk($sformatf("accept_w_%0h", t), {127'd0, ok}, 128'd1);
  endtask

  initial begin
    bit seen;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = '0;
    req_byteen = '0; req_data = '0; req_tag = '0;
    rsp_ready = 1'b1;
    req_valid_w = 1'b0; req_rw_w = 1'b0; req_addr_w = '0;
    req_byteen_w = '0; req_data_w = '0; req_tag_w = '0;
    rsp_ready_w = 1'b1;

    // reset held with a request offered
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
    end
    req_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("rel_ready", req_ready, 1);

    // write, partial write, read back
    send(1'b1, 6'd5, 16'hFFFF, '0, 8'h10);
    send(1'b1, 6'd5, 16'h00FF, {16{8'hAA}}, 8'h11);
    chk("wr_no_rsp", rsp_valid, 0);
    send(1'b0, 6'd5, '0, '0, 8'h22);
    chk("rd_lat0", rsp_valid, 0);
    chk("rd_busy", busy, 1);
    tick();
    chk("rd_lat1", rsp_valid, 0);
    tick();
    chk("rd_lat2", rsp_valid, 1);
    chk("rd_data", rsp_data, LINE5);
    chk("rd_tag", rsp_tag, 8'h22);
    tick();
    chk("rd_drained", rsp_valid, 0);
    chk("rd_idle", busy, 0);

    // backpressure and credit return
    got_tag.delete();
    got_data.delete();
    rsp_ready = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      send(1'b0, 6'd5, '0, '0, 8'(t));
    end
    req_rw = 1'b0; req_addr = 6'd5; req_tag = 8'd5;
    req_valid = 1'b1;
    #1;
    chk("bp_ready", req_ready, 0);
    tick(); tick(); tick();
    chk("bp_ready_hold", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_head_tag", rsp_tag, 8'd1);
    chk("bp_head_data", rsp_data, LINE5);
    rsp_ready = 1'b1;
    #1;
    chk("sim_ready", req_ready, 0);
    tick();
    chk("sim_ready_next", req_ready, 1);
    tick();
    req_tag = 8'd6;
    #1;
    chk("sim_ready_keep", req_ready, 1);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 30 && got_tag.size() < 6; i++) tick();
    chk("bp_count", 128'(got_tag.size()), 128'd6);
    for (int i = 0; i < 6 && i < got_tag.size(); i++) begin
      chk($sformatf("bp_order_%0d", i), got_tag[i], 8'(i + 1));
    end
    if (got_data.size() == 6) chk("bp_data6", got_data[5], LINE5);
    tick();
    chk("bp_idle", busy, 0);

    // write responses on the WRITE_RSP instance
    send_w(1'b1, 6'd9, 16'hFFFF, '0, 8'h06);
    send_w(1'b1, 6'd9, 16'h000F,
           {96'hDEADBEEF_CAFEF00D_01234567, 32'h12345678}, 8'h07);
    send_w(1'b0, 6'd9, '0, '0, 8'h08);
    for (int i = 0; i < 30 && got_tag_w.size() < 3; i++) tick();
    chk("wr_count", 128'(got_tag_w.size()), 128'd3);
    if (got_tag_w.size() == 3) begin
      chk("wr_tag0", got_tag_w[0], 8'h06);
      chk("wr_tag1", got_tag_w[1], 8'h07);
      chk("wr_data1", got_data_w[1], 128'd0);
      chk("wr_tag2", got_tag_w[2], 8'h08);
      chk("wr_rd_data", got_data_w[2], 128'h12345678);
    end
    tick();
    chk("wr_idle", busy_w, 0);

    // reset with reads in flight
    got_tag.delete();
    got_data.delete();
    send(1'b0, 6'd5, '0, '0, 8'h30);
    send(1'b0, 6'd5, '0, '0, 8'h31);
    reset = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    tick();
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    chk("mid_no_rsp", {127'd0, seen}, 128'd0);
    chk("mid_no_fire", 128'(got_tag.size()), 128'd0);
    chk("mid_idle", busy, 0);
    send(1'b0, 6'd5, '0, '0, 8'h32);
    for (int i = 0; i < 10 && !rsp_valid; i++) tick();
    chk("post_valid", rsp_valid, 1);
    chk("post_tag", rsp_tag, 8'h32);
    chk("post_data", rsp_data, LINE5);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
